// File: rtl/capture_sequencer_if.sv
// Control/status bundle between the capture sequencer and its host/row decoder.
// The sequencer uses the slave modport; the host side uses master.
interface capture_sequencer_if;
    logic        cfg_wr;
    logic [12:0] cfg_exp_lines;
    logic [7:0]  cfg_frames;
    logic [15:0] cfg_timeout;
    logic        start;
    logic        abort;
    logic        decoder_done;
    logic        dec_rst_n;
    logic        frame_req;
    logic [7:0]  frame_req_cnt;
    logic [12:0] exp_line_time_req;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    modport slave (
        input  cfg_wr, cfg_exp_lines, cfg_frames, cfg_timeout,
        input  start, abort, decoder_done,
        output dec_rst_n, frame_req, frame_req_cnt, exp_line_time_req,
        output busy, done, err_code
    );

    modport master (
        output cfg_wr, cfg_exp_lines, cfg_frames, cfg_timeout,
        output start, abort, decoder_done,
        input  dec_rst_n, frame_req, frame_req_cnt, exp_line_time_req,
        input  busy, done, err_code
    );
endinterface

// File: rtl/capture_sequencer.sv
// Sequences one row-decoder capture: decoder reset hold, trigger pulse,
// watchdog-supervised run, then a one-cycle completion report.
module capture_sequencer #(
    parameter int LINE_CLKS = 560,
    parameter int ARM_CLKS  = 4
) (
    input  logic                clk_rxg,
    input  logic                rst_rx_n,
    capture_sequencer_if.slave  bus
);
    localparam int LW = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
    localparam int AW = (ARM_CLKS > 1) ? $clog2(ARM_CLKS) : 1;
    localparam logic [12:0] EXP_MIN = 13'd2047;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_CFG   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_REQ,
        S_RUN,
        S_FIN
    } state_e;

    state_e      state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [15:0] period_q, period_d;
    logic [1:0]  err_q, err_d;

    logic [12:0] stg_exp_q;
    logic [7:0]  stg_frames_q;
    logic [15:0] stg_to_q;
    logic [12:0] sh_exp_q;
    logic [7:0]  sh_frames_q;
    logic [15:0] sh_to_q;

    logic cfg_ok;
    logic load_sh;
    logic line_wrap;
    logic tmo_hit;

    assign cfg_ok    = (stg_exp_q >= EXP_MIN) && (stg_frames_q != 8'd0);
    assign line_wrap = (line_q == LW'(LINE_CLKS - 1));
    // Fire on the wrap that brings the period count up to the limit, so RUN
    // spans exactly limit row periods before FIN.
    assign tmo_hit   = (sh_to_q != 16'd0) && line_wrap &&
                       (({1'b0, period_q} + 17'd1) == {1'b0, sh_to_q});

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        line_d    = line_q;
        period_d  = period_q;
        err_d     = err_q;
        load_sh   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    if (cfg_ok) begin
                        load_sh   = 1'b1;
                        err_d     = ERR_OK;
                        arm_cnt_d = '0;
                        state_d   = S_ARM;
                    end else begin
                        err_d   = ERR_CFG;
                        state_d = S_FIN;
                    end
                end
            end
            S_ARM: begin
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_FIN;
                end else if (arm_cnt_q == AW'(ARM_CLKS - 1)) begin
                    state_d = S_REQ;
                end else begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            S_REQ: begin
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_FIN;
                end else begin
                    line_d   = '0;
                    period_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                line_d   = line_wrap ? '0 : line_q + LW'(1);
                period_d = line_wrap ? period_q + 16'd1 : period_q;
                if (bus.decoder_done) begin
                    err_d   = ERR_OK;
                    state_d = S_FIN;
                end else if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = S_FIN;
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            state_q   <= S_IDLE;
            arm_cnt_q <= '0;
            line_q    <= '0;
            period_q  <= '0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            line_q    <= line_d;
            period_q  <= period_d;
            err_q     <= err_d;
        end
    end

    // Staging accepts writes at any time; only an accepted start samples it.
    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            stg_exp_q    <= '0;
            stg_frames_q <= '0;
            stg_to_q     <= '0;
        end else if (bus.cfg_wr) begin
            stg_exp_q    <= bus.cfg_exp_lines;
            stg_frames_q <= bus.cfg_frames;
            stg_to_q     <= bus.cfg_timeout;
        end
    end

    always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            sh_exp_q    <= '0;
            sh_frames_q <= '0;
            sh_to_q     <= '0;
        end else if (load_sh) begin
            sh_exp_q    <= stg_exp_q;
            sh_frames_q <= stg_frames_q;
            sh_to_q     <= stg_to_q;
        end
    end

    // Trigger is masked by a same-cycle abort so a cancelled REQ never pulses.
    assign bus.frame_req         = (state_q == S_REQ) && !bus.abort;
    assign bus.dec_rst_n         = (state_q == S_REQ) || (state_q == S_RUN);
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.done              = (state_q == S_FIN);
    assign bus.err_code          = err_q;
    assign bus.frame_req_cnt     = sh_frames_q;
    assign bus.exp_line_time_req = sh_exp_q;

endmodule
